// File: rtl/bram_h_fetch_if.sv
// Stream interface from the h-vector fetch sequencer to the CNN MAC stage.
//   m_valid  word valid (master -> slave)
//   m_ready  consumer ready (slave -> master); transfer on m_valid & m_ready
//   m_data   ROM word
//   m_index  ROM address the word was read from
//   m_last   final word of the pass
interface bram_h_fetch_if #(
  parameter int unsigned RAM_WIDTH = 4,
  parameter int unsigned ADDR_BITS = 6
);
  logic                 m_valid;
  logic                 m_ready;
  logic [RAM_WIDTH-1:0] m_data;
  logic [ADDR_BITS-1:0] m_index;
  logic                 m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/bram_h_fetch.sv
// h-vector ROM fetch sequencer. Owns the ROM address bus, walks START_ADDR..END_ADDR after a
// start request, registers the asynchronous ROM data and streams it out over valid/ready with
// index and last tags.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        1-cycle pass request, honoured only when idle
//   clr          synchronous abort (wins over start), no done pulse
//   addr_vector  ROM address
//   data_in      ROM data, combinational from addr_vector
//   m            output stream (bram_h_fetch_if.master)
//   busy         high while a pass is in progress
//   done         1-cycle pulse after the final word was accepted
//   repeat_cnt   (BRAM_FETCH_REPEAT_EN only) passes per start, 0 treated as 1
//
// Optional feature: define BRAM_FETCH_REPEAT_EN to replay the address range repeat_cnt times
// per start, back-to-back, with m_last/done only at the end of the final pass.
module bram_h_fetch #(
  parameter int unsigned RAM_WIDTH  = 4,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
`ifdef BRAM_FETCH_REPEAT_EN
  input  logic [7:0]           repeat_cnt,
`endif
  output logic [ADDR_BITS-1:0] addr_vector,
  input  logic [RAM_WIDTH-1:0] data_in,
  bram_h_fetch_if.master       m,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] StartAddr = ADDR_BITS'(START_ADDR);
  localparam logic [ADDR_BITS-1:0] EndAddr   = ADDR_BITS'(END_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] index_q, index_d;
  logic [RAM_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic at_end;
  logic final_word;
  logic load;

`ifdef BRAM_FETCH_REPEAT_EN
  // Passes still to run after the current one.
  logic [7:0] pass_q, pass_d;
  assign final_word = at_end && (pass_q == 8'd0);
`else
  assign final_word = at_end;
`endif

  assign at_end = (addr_q == EndAddr);
  // Output register may be refilled when empty or being drained this cycle.
  assign load   = !valid_q || m.m_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef BRAM_FETCH_REPEAT_EN
    pass_d  = pass_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = StartAddr;
`ifdef BRAM_FETCH_REPEAT_EN
          pass_d  = (repeat_cnt == 8'd0) ? 8'd0 : repeat_cnt - 8'd1;
`endif
        end
      end

      StRun: begin
        if (load) begin
          data_d  = data_in;
          index_d = addr_q;
          valid_d = 1'b1;
          last_d  = final_word;
          if (final_word) begin
            // Hold the address on the last word so it never wraps.
            state_d = StFlush;
          end else if (at_end) begin
`ifdef BRAM_FETCH_REPEAT_EN
            addr_d = StartAddr;
            pass_d = pass_q - 8'd1;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      StFlush: begin
        if (valid_q && m.m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Abort: nothing in flight survives, address bus keeps its current value.
    if (clr) begin
      state_d = StIdle;
      addr_d  = addr_q;
      index_d = index_q;
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
`ifdef BRAM_FETCH_REPEAT_EN
      pass_d  = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BRAM_FETCH_REPEAT_EN
      pass_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef BRAM_FETCH_REPEAT_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign addr_vector = addr_q;
  assign m.m_valid   = valid_q;
  assign m.m_data    = data_q;
  assign m.m_index   = index_q;
  assign m.m_last    = last_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;

endmodule

// File: tb/tb_bram_h_fetch.sv
module tb_bram_h_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main DUT: full 0..63 range, ROM[i] = i % 16.
  logic       start, clr, ready;
  logic [5:0] addr;
  logic [3:0] rom_data;
  logic       busy, done;
  bram_h_fetch_if #(.RAM_WIDTH(4), .ADDR_BITS(6)) s_if ();
  assign s_if.m_ready = ready;
  assign rom_data     = addr[3:0];

  // Single-address DUT: START_ADDR = END_ADDR = 5, ROM[5] = 4'hA.
  logic       start5, ready5;
  logic [5:0] addr5;
  logic [3:0] rom5_data;
  logic       busy5, done5;
  bram_h_fetch_if #(.RAM_WIDTH(4), .ADDR_BITS(6)) s5_if ();
  assign s5_if.m_ready = ready5;
  assign rom5_data     = (addr5 == 6'd5) ? 4'hA : addr5[3:0];

`ifdef BRAM_FETCH_REPEAT_EN
  logic [7:0] repeat_cnt = 8'd1;
`endif

  bram_h_fetch #(.RAM_WIDTH(4), .ADDR_BITS(6), .START_ADDR(0), .END_ADDR(63)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clr        (clr),
`ifdef BRAM_FETCH_REPEAT_EN
    .repeat_cnt (repeat_cnt),
`endif
    .addr_vector(addr),
    .data_in    (rom_data),
    .m          (s_if),
    .busy       (busy),
    .done       (done)
  );

  bram_h_fetch #(.RAM_WIDTH(4), .ADDR_BITS(6), .START_ADDR(5), .END_ADDR(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start5),
    .clr        (1'b0),
`ifdef BRAM_FETCH_REPEAT_EN
    .repeat_cnt (8'd1),
`endif
    .addr_vector(addr5),
    .data_in    (rom5_data),
    .m          (s5_if),
    .busy       (busy5),
    .done       (done5)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       start, clr, ready;
    logic       valid;
    logic [5:0] index;
    logic [3:0] data;
    logic       last, busy, done;
    logic [5:0] addr;
  } vec_t;

  // One start pulse then beats-many words at full rate; expects ROM[i] = i % 16, range 0..63.
  task automatic run_pass(input string tag, input int beats);
    @(negedge clk); start = 1'b1; ready = 1'b1; clr = 1'b0;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_t1"}, int'(busy), 1);
    chk({tag, "_valid_t1"}, int'(s_if.m_valid), 0);
    for (int c = 0; c < beats + 3; c++) begin
      @(negedge clk);
      if (c < beats) begin
        chk({tag, "_valid"}, int'(s_if.m_valid), 1);
        chk({tag, "_index"}, int'(s_if.m_index), c % 64);
        chk({tag, "_data"}, int'(s_if.m_data), c % 16);
        chk({tag, "_last"}, int'(s_if.m_last), (c == beats - 1) ? 1 : 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_done_early"}, int'(done), 0);
      end else if (c == beats) begin
        chk({tag, "_valid_end"}, int'(s_if.m_valid), 0);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy_end"}, int'(busy), 0);
      end else begin
        chk({tag, "_done_once"}, int'(done), 0);
        chk({tag, "_valid_idle"}, int'(s_if.m_valid), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   exp_idx, dones, accepts, n;
    bit   held, rdy_next, reached;
    logic [3:0] hold_data;
    logic [5:0] hold_index;
    logic       hold_last;

    //        st clr rdy  val idx dat lst bsy dn addr
    vecs[0]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0, 0};
    vecs[1]  = '{1, 0, 0,  0,  0,  0,  0,  1,  0, 0};
    vecs[2]  = '{0, 0, 0,  1,  0,  0,  0,  1,  0, 1};
    vecs[3]  = '{0, 0, 0,  1,  0,  0,  0,  1,  0, 1};
    vecs[4]  = '{1, 0, 0,  1,  0,  0,  0,  1,  0, 1};  // start while busy ignored
    vecs[5]  = '{0, 0, 1,  1,  1,  1,  0,  1,  0, 2};
    vecs[6]  = '{0, 0, 1,  1,  2,  2,  0,  1,  0, 3};
    vecs[7]  = '{0, 0, 0,  1,  2,  2,  0,  1,  0, 3};
    vecs[8]  = '{1, 1, 1,  0,  0,  0,  0,  0,  0, 3};  // clr beats start, addr kept
    vecs[9]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0, 3};
    vecs[10] = '{1, 0, 1,  0,  0,  0,  0,  1,  0, 0};
    vecs[11] = '{0, 0, 1,  1,  0,  0,  0,  1,  0, 1};
    vecs[12] = '{0, 0, 1,  1,  1,  1,  0,  1,  0, 2};
    vecs[13] = '{0, 1, 1,  0,  0,  0,  0,  0,  0, 2};

    // Reset state
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; ready = 1'b0; start5 = 1'b0; ready5 = 1'b0;
    #1;
    chk("rst_valid", int'(s_if.m_valid), 0);
    chk("rst_last", int'(s_if.m_last), 0);
    chk("rst_data", int'(s_if.m_data), 0);
    chk("rst_index", int'(s_if.m_index), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst5_addr", int'(addr5), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycle vectors: inputs at negedge, outputs checked next negedge.
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; clr = vecs[i].clr; ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), int'(s_if.m_valid), int'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_index", i), int'(s_if.m_index), int'(vecs[i].index));
        chk($sformatf("vec%0d_data", i), int'(s_if.m_data), int'(vecs[i].data));
      end
      chk($sformatf("vec%0d_last", i), int'(s_if.m_last), int'(vecs[i].last));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
      chk($sformatf("vec%0d_addr", i), int'(addr), int'(vecs[i].addr));
    end
    start = 1'b0; clr = 1'b0; ready = 1'b0;

    // Full pass at full rate
    run_pass("pass", 64);

    // m_ready toggling every cycle: ordered, no drop/dup, stable while stalled
    @(negedge clk); start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    exp_idx = 0; dones = 0; held = 1'b0; rdy_next = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (held) begin
        chk("stall_data", int'(s_if.m_data), int'(hold_data));
        chk("stall_index", int'(s_if.m_index), int'(hold_index));
        chk("stall_last", int'(s_if.m_last), int'(hold_last));
        held = 1'b0;
      end
      if (done) dones++;
      if (s_if.m_valid) begin
        if (rdy_next) begin
          chk("tog_index", int'(s_if.m_index), exp_idx);
          chk("tog_data", int'(s_if.m_data), exp_idx % 16);
          chk("tog_last", int'(s_if.m_last), (exp_idx == 63) ? 1 : 0);
          exp_idx++;
        end else begin
          hold_data = s_if.m_data; hold_index = s_if.m_index; hold_last = s_if.m_last;
          held = 1'b1;
        end
      end
      ready = rdy_next;
      rdy_next = !rdy_next;
      @(negedge clk);
    end
    chk("tog_count", exp_idx, 64);
    chk("tog_dones", dones, 1);
    ready = 1'b0;

    // START_ADDR == END_ADDR: single beat
    @(negedge clk); start5 = 1'b1; ready5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    chk("single_busy", int'(busy5), 1);
    chk("single_valid_t1", int'(s5_if.m_valid), 0);
    @(negedge clk);
    chk("single_valid", int'(s5_if.m_valid), 1);
    chk("single_data", int'(s5_if.m_data), 10);
    chk("single_index", int'(s5_if.m_index), 5);
    chk("single_last", int'(s5_if.m_last), 1);
    chk("single_addr", int'(addr5), 5);
    @(negedge clk);
    chk("single_done", int'(done5), 1);
    chk("single_valid_end", int'(s5_if.m_valid), 0);
    chk("single_busy_end", int'(busy5), 0);
    @(negedge clk);
    chk("single_done_once", int'(done5), 0);
    ready5 = 1'b0;

    // clr after 10 accepted words
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    accepts = 0; reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (s_if.m_valid && ready) accepts++;
      @(negedge clk);
      if (accepts == 10) reached = 1'b1;
    end
    chk("clr_reached10", int'(reached), 1);
    chk("clr_pre_index", int'(s_if.m_index), 10);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_valid", int'(s_if.m_valid), 0);
    chk("clr_last", int'(s_if.m_last), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_addr", int'(addr), 11);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy || s_if.m_valid) n++;
    end
    chk("clr_quiet", n, 0);
    run_pass("restart", 64);

    // Asynchronous reset mid-pass
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(s_if.m_valid), 0);
    chk("arst_last", int'(s_if.m_last), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_addr", int'(addr), 0);
    chk("arst_index", int'(s_if.m_index), 0);
    chk("arst_data", int'(s_if.m_data), 0);
    @(negedge clk); rst_n = 1'b1;
    run_pass("post_rst", 64);

`ifdef BRAM_FETCH_REPEAT_EN
    repeat_cnt = 8'd3;
    run_pass("rep3", 192);
    repeat_cnt = 8'd0;
    run_pass("rep0", 64);
    repeat_cnt = 8'd1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
